// File: rtl/cpu_pkg.sv
// Shared CPU types: memory interface widths/modes plus the memory arbiter's
// owner and state encodings.
package cpu_pkg;

  localparam int MEMORY_ADDR_WIDTH = 8;
  localparam int MEMORY_DATA_WIDTH = 8;
  localparam int INSTRN_DATA_WIDTH = MEMORY_DATA_WIDTH;

  typedef logic [MEMORY_ADDR_WIDTH-1:0] memory_address_t;
  typedef logic [MEMORY_DATA_WIDTH-1:0] memory_data_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } memory_mode_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_owner_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

  // Cycles allowed in WAIT_RSP before the arbiter answers with an error.
  localparam int ARB_RSP_TIMEOUT = 16;

  function automatic arb_owner_t arb_other(input arb_owner_t owner);
    return (owner == FETCH) ? DATA : FETCH;
  endfunction

endpackage

// File: rtl/cpu_rr_arb2.sv
// Two-way round-robin grant picker: a lone requester always wins, a tie goes
// to whichever requester did not win last time.
module cpu_rr_arb2
  import cpu_pkg::*;
(
  input  logic       fetch_valid_i,
  input  logic       data_valid_i,
  input  arb_owner_t last_grant_i,
  output logic [1:0] grant_o
);

  // grant_o[0] = fetch, grant_o[1] = data; at most one bit set.
  always_comb begin
    grant_o = 2'b00;
    if (fetch_valid_i && data_valid_i) begin
      grant_o = (arb_other(last_grant_i) == FETCH) ? 2'b01 : 2'b10;
    end else if (fetch_valid_i) begin
      grant_o = 2'b01;
    end else if (data_valid_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access:
// round-robin grant, one outstanding transaction, response watchdog.
//
// Handshakes: a request transfers on a rising edge where valid && ready are
// both high. Requesters must hold valid and payload until that edge; the
// memory-side request is held stable from the first ISSUE cycle until
// mem_req_ready. Responses are single-cycle pulses with no back-pressure.
module cpu_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = MEMORY_ADDR_WIDTH,
  parameter int DATA_WIDTH  = MEMORY_DATA_WIDTH,
  parameter int RSP_TIMEOUT = ARB_RSP_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_rsp_valid,
  output logic [DATA_WIDTH-1:0] i_rsp_data,
  output logic                  i_rsp_err,

  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  memory_mode_t          d_req_mode,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  d_rsp_err,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output memory_mode_t          mem_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,

  output logic                  proto_err
);

  localparam bit TIMEOUT_ON = (RSP_TIMEOUT != 0);
  localparam int WD_W = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(RSP_TIMEOUT - 1);

  arb_state_t            state_q,      state_d;
  arb_owner_t            last_grant_q, last_grant_d;
  arb_owner_t            owner_q,      owner_d;
  memory_mode_t          mode_q,       mode_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
  logic [WD_W-1:0]       wd_q,         wd_d;
  logic                  i_rsp_valid_q, i_rsp_valid_d;
  logic [DATA_WIDTH-1:0] i_rsp_data_q,  i_rsp_data_d;
  logic                  i_rsp_err_q,   i_rsp_err_d;
  logic                  d_rsp_valid_q, d_rsp_valid_d;
  logic [DATA_WIDTH-1:0] d_rsp_data_q,  d_rsp_data_d;
  logic                  d_rsp_err_q,   d_rsp_err_d;
  logic                  proto_err_q,  proto_err_d;

  logic [1:0]            grant;
  logic                  i_hs;
  logic                  d_hs;
  logic                  rsp_fire;
  logic [DATA_WIDTH-1:0] rsp_data_sel;
  logic                  rsp_err_sel;

  cpu_rr_arb2 u_rr_arb2 (
    .fetch_valid_i (i_req_valid),
    .data_valid_i  (d_req_valid),
    .last_grant_i  (last_grant_q),
    .grant_o       (grant)
  );

  assign i_req_ready = (state_q == IDLE) && grant[0];
  assign d_req_ready = (state_q == IDLE) && grant[1];
  assign i_hs        = i_req_valid && i_req_ready;
  assign d_hs        = d_req_valid && d_req_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wd_d         = wd_q;
    rsp_fire     = 1'b0;
    rsp_data_sel = '0;
    rsp_err_sel  = 1'b0;
    // Any memory response we are not waiting for is dropped and remembered.
    proto_err_d  = proto_err_q | (mem_rsp_valid && (state_q != WAIT_RSP));

    case (state_q)
      IDLE: begin
        if (i_hs) begin
          owner_d      = FETCH;
          mode_d       = READ;
          addr_d       = i_req_addr;
          wdata_d      = '0;
          last_grant_d = FETCH;
          state_d      = ISSUE;
        end else if (d_hs) begin
          owner_d      = DATA;
          mode_d       = d_req_mode;
          addr_d       = d_req_addr;
          wdata_d      = d_req_wdata;
          last_grant_d = DATA;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        if (mem_req_ready) begin
          if (mode_q == READ) begin
            wd_d    = '0;
            state_d = WAIT_RSP;
          end else begin
            // Store ack carries no data.
            rsp_fire = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      WAIT_RSP: begin
        // Data beats a simultaneous timeout.
        if (mem_rsp_valid) begin
          rsp_fire     = 1'b1;
          rsp_data_sel = mem_rsp_data;
          state_d      = IDLE;
        end else if (TIMEOUT_ON && (wd_q == WD_LAST)) begin
          rsp_fire    = 1'b1;
          rsp_err_sel = 1'b1;
          state_d     = IDLE;
        end else if (TIMEOUT_ON) begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    i_rsp_valid_d = rsp_fire && (owner_q == FETCH);
    i_rsp_data_d  = (rsp_fire && (owner_q == FETCH)) ? rsp_data_sel : '0;
    i_rsp_err_d   = rsp_fire && (owner_q == FETCH) && rsp_err_sel;
    d_rsp_valid_d = rsp_fire && (owner_q == DATA);
    d_rsp_data_d  = (rsp_fire && (owner_q == DATA)) ? rsp_data_sel : '0;
    d_rsp_err_d   = rsp_fire && (owner_q == DATA) && rsp_err_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= DATA;
      owner_q       <= FETCH;
      mode_q        <= READ;
      addr_q        <= '0;
      wdata_q       <= '0;
      wd_q          <= '0;
      i_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= '0;
      i_rsp_err_q   <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_data_q  <= '0;
      d_rsp_err_q   <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      mode_q        <= mode_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wd_q          <= wd_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      i_rsp_data_q  <= i_rsp_data_d;
      i_rsp_err_q   <= i_rsp_err_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_data_q  <= d_rsp_data_d;
      d_rsp_err_q   <= d_rsp_err_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_mode      = mode_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;

  assign i_rsp_valid   = i_rsp_valid_q;
  assign i_rsp_data    = i_rsp_data_q;
  assign i_rsp_err     = i_rsp_err_q;
  assign d_rsp_valid   = d_rsp_valid_q;
  assign d_rsp_data    = d_rsp_data_q;
  assign d_rsp_err     = d_rsp_err_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: behavioural memory, request drivers and an
// in-order response scoreboard carrying owner, error, data and latency.
module tb_cpu_mem_arbiter;
  import cpu_pkg::*;

  localparam int SBW = 10;  // {owner, err, data}

  logic         clk;
  logic         rst;
  logic         i_req_valid;
  logic         i_req_ready;
  logic [7:0]   i_req_addr;
  logic         i_rsp_valid;
  logic [7:0]   i_rsp_data;
  logic         i_rsp_err;
  logic         d_req_valid;
  logic         d_req_ready;
  memory_mode_t d_req_mode;
  logic [7:0]   d_req_addr;
  logic [7:0]   d_req_wdata;
  logic         d_rsp_valid;
  logic [7:0]   d_rsp_data;
  logic         d_rsp_err;
  logic         mem_req_valid;
  logic         mem_req_ready;
  memory_mode_t mem_mode;
  logic [7:0]   mem_addr;
  logic [7:0]   mem_wdata;
  logic         mem_rsp_valid;
  logic [7:0]   mem_rsp_data;
  logic         proto_err;

  cpu_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RSP_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .i_req_ready   (i_req_ready),
    .i_req_addr    (i_req_addr),
    .i_rsp_valid   (i_rsp_valid),
    .i_rsp_data    (i_rsp_data),
    .i_rsp_err     (i_rsp_err),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_req_mode    (d_req_mode),
    .d_req_addr    (d_req_addr),
    .d_req_wdata   (d_req_wdata),
    .d_rsp_valid   (d_rsp_valid),
    .d_rsp_data    (d_rsp_data),
    .d_rsp_err     (d_rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_mode      (mem_mode),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .proto_err     (proto_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- scoreboard ----------------
  logic [SBW-1:0] exp_q[$];
  int             lat_q[$];
  int             hs_q[$];

  logic [7:0] ref_mem [256];
  logic [7:0] mem_array [256];

  function automatic logic [7:0] init_val(input int a);
    logic [7:0] v;
    v = 8'(a) ^ 8'hA5;
    if (a == 8'h10) v = 8'h3A;
    return v;
  endfunction

  always @(negedge clk) begin
    logic [SBW-1:0] got;
    logic [SBW-1:0] e;
    int l;
    int t;
    if (!rst) begin
      if (i_rsp_valid || d_rsp_valid) begin
        check_eq("rsp_one_owner", 32'(i_rsp_valid && d_rsp_valid), 32'd0);
        got = {d_rsp_valid, (i_rsp_valid ? i_rsp_err : d_rsp_err),
               (i_rsp_valid ? i_rsp_data : d_rsp_data)};
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 32'(got), 32'h3FF);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          t = hs_q.pop_front();
          check_eq("rsp_owner_err_data", 32'(got), 32'(e));
          check_eq("rsp_latency", 32'(cyc - t), 32'(l));
        end
      end else begin
        check_eq("rsp_idle_zero", {16'd0, i_rsp_data, d_rsp_data} | {30'd0, i_rsp_err, d_rsp_err}, 32'd0);
      end
    end
  end

  // ---------------- memory model ----------------
  int           stall_left = 0;
  bit           mem_mute   = 0;
  bit           spur       = 0;
  bit           acc_pend   = 0;
  memory_mode_t acc_mode   = READ;
  logic [7:0]   acc_addr   = '0;
  logic [7:0]   acc_wdata  = '0;

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  end

  always @(negedge clk) begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_req_ready = 1'b0;
    if (rst) begin
      acc_pend = 0;
    end else begin
      if (acc_pend) begin
        if (acc_mode == WRITE) mem_array[acc_addr] = acc_wdata;
        else if (!mem_mute) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_array[acc_addr];
        end
        acc_pend = 0;
      end else if (spur) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 8'hEE;
        spur = 0;
      end
      if (mem_req_valid) begin
        if (stall_left > 0) stall_left--;
        else begin
          mem_req_ready = 1'b1;
          acc_pend  = 1;
          acc_mode  = mem_mode;
          acc_addr  = mem_addr;
          acc_wdata = mem_wdata;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_one(input arb_owner_t own, input memory_mode_t mode, input logic [7:0] addr,
                          input logic [7:0] wd, input logic [SBW-1:0] exp, input int lat);
    int guard;
    bit done;
    guard = 0;
    done  = 0;
    @(negedge clk);
    if (own == FETCH) begin
      i_req_valid = 1'b1;
      i_req_addr  = addr;
    end else begin
      d_req_valid = 1'b1;
      d_req_mode  = mode;
      d_req_addr  = addr;
      d_req_wdata = wd;
    end
    while (!done && guard < 100) begin
      #1;
      if ((own == FETCH && i_req_ready) || (own == DATA && d_req_ready)) begin
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        hs_q.push_back(cyc);
        done = 1;
      end
      @(negedge clk);
      guard++;
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    check_eq("req_handshake", 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    arb_owner_t grants[6];
    int         ngr;
    int         guard;
    logic [7:0] fa;
    logic [7:0] da;
    logic [7:0] ra;
    bit         any_rsp;

    for (int a = 0; a < 256; a++) begin
      ref_mem[a]   = init_val(a);
      mem_array[a] = init_val(a);
    end
    rst = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    d_req_valid = 1'b0;
    d_req_mode  = READ;
    d_req_addr  = '0;
    d_req_wdata = '0;

    // Reset state
    @(negedge clk);
    check_eq("reset_quiet", {i_req_ready, d_req_ready, i_rsp_valid, i_rsp_err, d_rsp_valid, d_rsp_err,
                             mem_req_valid, mem_mode, i_rsp_data, d_rsp_data, mem_addr, mem_wdata}, 32'd0);
    check_eq("reset_proto_err", 32'(proto_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Lone fetch, memory answers the cycle after accept
    send_one(FETCH, READ, 8'h10, 8'h00, {FETCH, 1'b0, 8'h3A}, 3);
    wait_idle(20);

    // Both requesters valid every cycle from a fresh reset
    do_reset();
    ngr = 0;
    guard = 0;
    fa = 8'h00;
    da = 8'h80;
    while (ngr < 6 && guard < 200) begin
      @(negedge clk);
      i_req_valid = 1'b1;
      i_req_addr  = fa;
      d_req_valid = 1'b1;
      d_req_mode  = READ;
      d_req_addr  = da;
      #1;
      if (i_req_ready && d_req_ready) check_eq("tie_single_grant", 32'd1, 32'd0);
      if (i_req_ready) begin
        exp_q.push_back({FETCH, 1'b0, ref_mem[fa]});
        lat_q.push_back(3);
        hs_q.push_back(cyc);
        grants[ngr] = FETCH;
        ngr++;
        fa++;
      end else if (d_req_ready) begin
        exp_q.push_back({DATA, 1'b0, ref_mem[da]});
        lat_q.push_back(3);
        hs_q.push_back(cyc);
        grants[ngr] = DATA;
        ngr++;
        da++;
      end
      guard++;
    end
    @(negedge clk);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    check_eq("tie_grant_count", 32'(ngr), 32'd6);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("tie_grant_%0d", k), 32'(grants[k]), 32'(k % 2));
    end
    wait_idle(20);

    // Store with memory stalling four cycles
    stall_left = 4;
    ref_mem[8'h44] = 8'h5C;
    send_one(DATA, WRITE, 8'h44, 8'h5C, {DATA, 1'b0, 8'h00}, 6);
    for (int i = 0; i < 5; i++) begin
      check_eq("store_hold_fields", {mem_req_valid, mem_mode, mem_addr, mem_wdata},
               {1'b1, WRITE, 8'h44, 8'h5C});
      check_eq("store_no_early_ack", 32'(d_rsp_valid), 32'd0);
      if (i < 4) @(negedge clk);
    end
    wait_idle(20);
    send_one(DATA, READ, 8'h44, 8'h00, {DATA, 1'b0, 8'h5C}, 3);
    wait_idle(20);

    // Random-address loads and fetches
    for (int n = 0; n < 6; n++) begin
      ra = 8'($urandom_range(0, 255));
      if (n % 2 == 0) send_one(FETCH, READ, ra, 8'h00, {FETCH, 1'b0, ref_mem[ra]}, 3);
      else            send_one(DATA, READ, ra, 8'h00, {DATA, 1'b0, ref_mem[ra]}, 3);
      wait_idle(20);
    end

    // Silent memory: watchdog answers with an error
    mem_mute = 1;
    send_one(DATA, READ, 8'h22, 8'h00, {DATA, 1'b1, 8'h00}, 18);
    wait_idle(40);
    mem_mute = 0;
    send_one(FETCH, READ, 8'h23, 8'h00, {FETCH, 1'b0, ref_mem[8'h23]}, 3);
    wait_idle(20);

    // Spurious memory response while idle
    check_eq("proto_err_before_spur", 32'(proto_err), 32'd0);
    spur = 1;
    repeat (3) @(negedge clk);
    check_eq("proto_err_set", 32'(proto_err), 32'd1);
    send_one(FETCH, READ, 8'h30, 8'h00, {FETCH, 1'b0, ref_mem[8'h30]}, 3);
    wait_idle(20);
    check_eq("proto_err_sticky", 32'(proto_err), 32'd1);
    do_reset();
    check_eq("proto_err_cleared", 32'(proto_err), 32'd0);

    // Reset while waiting for a response
    mem_mute = 1;
    send_one(DATA, READ, 8'h66, 8'h00, {DATA, 1'b0, 8'h00}, 3);
    repeat (2) @(negedge clk);
    check_eq("pre_rst_addr", 32'(mem_addr), 32'h66);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_quiet", {i_req_ready, d_req_ready, i_rsp_valid, i_rsp_err, d_rsp_valid, d_rsp_err,
                                 mem_req_valid, mem_mode, i_rsp_data, d_rsp_data, mem_addr, mem_wdata}, 32'd0);
    exp_q.delete();
    lat_q.delete();
    hs_q.delete();
    @(negedge clk);
    rst = 1'b0;
    mem_mute = 0;
    spur = 1;
    any_rsp = 0;
    repeat (3) begin
      @(negedge clk);
      any_rsp = any_rsp | i_rsp_valid | d_rsp_valid;
    end
    check_eq("late_rsp_dropped", 32'(any_rsp), 32'd0);
    check_eq("late_rsp_proto_err", 32'(proto_err), 32'd1);

    send_one(FETCH, READ, 8'h70, 8'h00, {FETCH, 1'b0, ref_mem[8'h70]}, 3);
    wait_idle(20);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
